// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio output stage.
// Optional build macro AUDIO_ADV_SYNC_EN is consumed by audio_out_stage.
package audio_pkg;

   localparam int SAMPLE_W = 24;
   localparam int GAIN_W   = 5;
   localparam logic [GAIN_W-1:0] GAIN_UNITY = 5'd16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic [GAIN_W-1:0]          gain_t;

   typedef enum logic [1:0] {
      IDLE,
      SCALE,
      OUT
   } out_state_t;

   // Volume 15 maps to unity, so the target never exceeds GAIN_UNITY.
   function automatic gain_t gain_target(input logic i_mute, input logic [3:0] i_vol);
      return i_mute ? gain_t'(0) : gain_t'({1'b0, i_vol} + 5'd1);
   endfunction

   function automatic gain_t gain_step(input gain_t i_cur, input gain_t i_tgt);
      if (i_cur < i_tgt)
         return i_cur + 5'd1;
      else if (i_cur > i_tgt)
         return i_cur - 5'd1;
      else
         return i_cur;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small first-word-fall-through FIFO; dout always shows the oldest entry.
// Callers qualify push/pop against full/empty.
module sample_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 24
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge i_clk) begin
      if (i_push)
         r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push)
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (i_pop)
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CNT_FULL);
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/audio_out_stage.sv
// Mixer-to-codec output stage: FIFO, ramped master gain/mute, codec write handshake.
// Define AUDIO_ADV_SYNC_EN to treat sample_valid as a raw asynchronous advance clock.
module audio_out_stage #(
   parameter int DEPTH    = 8,
   parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
   parameter int OVF_W    = 8
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic [3:0]          master_vol,
   input  logic                mute,
   input  logic                write_ready,
   output logic                write,
   output logic [SAMPLE_W-1:0] writedata_left,
   output logic [SAMPLE_W-1:0] writedata_right,
   output logic                fifo_full,
   output logic [OVF_W-1:0]    overflow_cnt
);

   import audio_pkg::*;

   localparam int PW = SAMPLE_W + 5;
   localparam logic [OVF_W-1:0] OVF_ONE = OVF_W'(1);

   logic                       w_push_stb;
   logic [SAMPLE_W-1:0]        w_push_data;
   logic                       w_push;
   logic                       w_pop;
   logic                       w_drop;
   logic                       w_fifo_full;
   logic                       w_fifo_empty;
   logic [SAMPLE_W-1:0]        w_fifo_dout;
   logic signed [PW-1:0]       w_product;
   logic signed [SAMPLE_W-1:0] w_scaled;
   logic                       w_unused_bits;

   out_state_t                 r_state;
   logic signed [SAMPLE_W-1:0] r_sample;
   logic signed [SAMPLE_W-1:0] r_wdata;
   gain_t                      r_gain;
   logic [OVF_W-1:0]           r_ovf;

`ifdef AUDIO_ADV_SYNC_EN
   logic                r_sync1;
   logic                r_sync2;
   logic                r_sync3;
   logic                r_push_stb;
   logic [SAMPLE_W-1:0] r_push_data;

   // sample_in must be stable around the raw edge; it is captured with the detected edge.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_sync3     <= 1'b0;
         r_push_stb  <= 1'b0;
         r_push_data <= '0;
      end else begin
         r_sync1    <= sample_valid;
         r_sync2    <= r_sync1;
         r_sync3    <= r_sync2;
         r_push_stb <= r_sync2 & ~r_sync3;
         if (r_sync2 & ~r_sync3)
            r_push_data <= sample_in;
      end
   end

   assign w_push_stb  = r_push_stb;
   assign w_push_data = r_push_data;
`else
   assign w_push_stb  = sample_valid;
   assign w_push_data = sample_in;
`endif

   // A push into a full FIFO still succeeds when the FSM pops in the same cycle.
   assign w_pop  = (r_state == IDLE) && !w_fifo_empty;
   assign w_push = w_push_stb && (!w_fifo_full || w_pop);
   assign w_drop = w_push_stb && w_fifo_full && !w_pop;

   sample_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_fifo (
      .i_clk   (CLOCK_50),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_push_data),
      .o_dout  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // g <= 16, so bits [SAMPLE_W+3:4] hold the floored, non-saturating result.
   assign w_product     = PW'(r_sample) * PW'($signed({1'b0, r_gain}));
   assign w_scaled      = w_product[SAMPLE_W+3:4];
   assign w_unused_bits = ^{w_product[PW-1:SAMPLE_W+4], w_product[3:0]};

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_sample <= '0;
         r_wdata  <= '0;
         r_gain   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_fifo_empty) begin
                  r_sample <= w_fifo_dout;
                  r_state  <= SCALE;
               end
            end
            SCALE: begin
               r_wdata <= w_scaled;
               r_gain  <= gain_step(r_gain, gain_target(mute, master_vol));
               r_state <= OUT;
            end
            OUT: begin
               if (write_ready)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset)
         r_ovf <= '0;
      else if (w_drop && (r_ovf != '1))
         r_ovf <= r_ovf + OVF_ONE;
   end

   // OUT always returns to IDLE after a write, so strobes can never be adjacent.
   assign write           = (r_state == OUT) && write_ready;
   assign writedata_left  = r_wdata;
   assign writedata_right = r_wdata;
   assign fifo_full       = w_fifo_full;
   assign overflow_cnt    = r_ovf;

endmodule

// File: doc/audio_out_stage.md
Name: audio_out_stage

Overview:
- Sits directly downstream of the voice mixer: consumes its signed 24-bit mixed sample on each advance strobe.
- Buffers samples in a small FIFO and applies a click-free ramped master gain/mute.
- Hands each sample to the DE1-SoC audio codec write interface (write_ready/write handshake), with the same data on left and right.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=2)
- SAMPLE_W, 24, sample width in bits (signed two's complement)
- OVF_W, 8, overflow counter width

Ports:
- CLOCK_50  input  1  single system clock; all state on its rising edge
- reset  input  1  asynchronous, active-low reset
- sample_in  input  SAMPLE_W  signed mixed sample from the mixer
- sample_valid  input  1  single-cycle strobe, sample_in valid (synchronous to CLOCK_50)
- master_vol  input  4  master volume 0..15
- mute  input  1  target gain 0 while high
- write_ready  input  1  codec can accept a stereo sample
- write  output  1  one-cycle codec write strobe
- writedata_left  output  SAMPLE_W  scaled sample
- writedata_right  output  SAMPLE_W  identical to writedata_left
- fifo_full  output  1  FIFO count == DEPTH
- overflow_cnt  output  OVF_W  samples dropped, saturating

Behaviour:
- Reset (reset==0, async): write=0, writedata_*=0, fifo empty, fifo_full=0, overflow_cnt=0, gain=0, FSM=IDLE. Reset mid-transfer abandons the held sample.
- FIFO: push on sample_valid when not full, or when full and a pop occurs the same cycle (count unchanged).
  - Push while full with no pop: sample dropped, overflow_cnt += 1, saturating at all-ones.
- Gain register g is 5 bits, range 0..16; 16 is unity.
  - target = mute ? 0 : master_vol+1.
  - g steps by exactly 1 toward target once per sample processed, after that sample is scaled.
- Scaling: product = sample * g as a signed 29-bit value. Result = product >>> 4 (arithmetic, floors toward -inf), truncated to SAMPLE_W. Because g<=16, |result|<=|sample| and no saturation occurs.
- FSM states:
  - IDLE: if FIFO non-empty, pop into s_reg and go to SCALE; otherwise stay.
  - SCALE: register the result into writedata_*, update g, go to OUT.
  - OUT: if write_ready, assert write for that cycle and go to IDLE; otherwise hold, with writedata_* stable.
- Latency: with empty FIFO, IDLE state and write_ready high, sample_valid at cycle t gives write=1 at t+3. Throughput is one sample per 3 cycles, far above the 48 kHz rate.
- Capacity while codec stalls: DEPTH in FIFO + 1 held in OUT.
- writedata_* change only on the SCALE->OUT transition.
- write is never asserted while write_ready is low, and never on two consecutive cycles.

Optional Feature:
- Macro AUDIO_ADV_SYNC_EN.
- Defined: sample_valid is treated as an asynchronous level (the raw advance clock). It passes through a 2-flop synchronizer plus rising-edge detect, which forms the internal push strobe. sample_in is captured on that strobe, so it must be stable across the edge. Latency becomes t+6 from the raw rising edge.
- Undefined: sample_valid is used directly as a synchronous one-cycle strobe; no extra flops.

Decomposition:
- Package audio_pkg:
  - SAMPLE_W
  - typedef sample_t (logic signed [SAMPLE_W-1:0])
  - typedef gain_t (logic [4:0])
  - localparam GAIN_UNITY=16
  - enum out_state_t {IDLE, SCALE, OUT}
- Sub-module sample_fifo (parameter DEPTH, width SAMPLE_W):
  - Provides push, pop, full, empty, dout.
  - Pointers wrap modulo DEPTH; count is a separate register.
- Gain, FSM and the overflow counter stay in audio_out_stage.

Test Plan:
- Ramp-up: after reset, master_vol=15, mute=0, write_ready=1; 17 samples of 24'h100000 spaced 10 cycles apart -> writedata_left = k*24'h010000 for k=0..16, the last equals 24'h100000, and writedata_right==writedata_left.
- Latency/handshake: with g=16, one strobe at cycle t with sample 24'h000123 -> write=1 only at t+3 with data 24'h000123; hold write_ready=0 for 20 cycles -> write stays 0 and data stays stable, write fires the cycle write_ready returns.
- Negative rounding: g held at 8 (master_vol=7, settled), sample -17 -> output 24'hFFFFF7 (-9); sample -16 at g=16 -> 24'hFFFFF0.
- Overflow: write_ready=0, 10 back-to-back strobes -> fifo_full=1, overflow_cnt=1; release write_ready -> exactly 9 writes, in order.
- Mute ramp: settled at g=16, assert mute, stream 24'h100000 -> outputs 24'h100000, then 24'h0F0000, 24'h0E0000 ... down to 0, then 0 thereafter.
- Async reset mid-operation: drop reset during OUT with FIFO holding 5 samples -> write, writedata_*, overflow_cnt go 0 without a clock edge; after release, no write until a new sample arrives, and that first output is 0 (g=0).
